wbi_master_port: RTL
====================

Name: wbi_master_port

Overview:
- Bridges one classic Wishbone master (stb/cyc/ack) onto the split command/response valid-ready channels of the interconnect daisy chain.
- Sits directly upstream of the interconnect command/response staging register.
- Tags every command with a fixed per-master transaction ID.
- Returns only responses carrying that ID to the master.

Parameters:
AW, 32, address width
DW, 32, data width
BW, 4, byte-select width (DW/8)
BL, 10, burst-count width
TID, 4'h0, transaction ID driven on every command and matched on responses
TO_CYC, 1023, response timeout in cycles (used only with optional feature)

Ports:
mclk  in  1  system clock
reset  in  1  synchronous active-high reset
wbm_stb_i  in  1  Wishbone strobe
wbm_cyc_i  in  1  Wishbone cycle
wbm_adr_i  in  AW  address
wbm_we_i  in  1  write enable
wbm_dat_i  in  DW  write data
wbm_sel_i  in  BW  byte select
wbm_bl_i  in  BL  read burst length (0 treated as 1)
wbm_dat_o  out  DW  read data
wbm_ack_o  out  1  beat acknowledge
wbm_lack_o  out  1  last-beat acknowledge
wbm_err_o  out  1  error, qualifies wbm_ack_o
cmd_wrdy_i  in  1  command channel ready
cmd_wval_o  out  1  command valid
cmd_adr_o  out  AW  command address
cmd_we_o  out  1  command write
cmd_dat_o  out  DW  command data
cmd_sel_o  out  BW  command byte select
cmd_tid_o  out  4  command ID (=TID)
cmd_bl_o  out  BL  command burst count
res_rrdy_o  out  1  response ready
res_rval_i  in  1  response valid
res_dat_i  in  DW  response data
res_ack_i  in  1  response ack
res_lack_i  in  1  response last beat
res_err_i  in  1  response error
res_tid_i  in  4  response ID

Behaviour:
Interface decision:
- One clock, mclk.
- reset is synchronous, active-high.

Reset:
- State goes to IDLE.
- All outputs are 0, except cmd_tid_o, which is TID.
- Beat counter is cleared.
- Reset mid-transaction abandons the transaction. No ack is issued.

FSM states: IDLE, CMD, RESP, DONE.
- IDLE:
  - On stb&cyc, register adr/we/dat/sel.
  - cmd_bl_o = we ? 1 : max(wbm_bl_i, 1).
  - Load beat counter with cmd_bl_o. Go to CMD.
- CMD:
  - cmd_wval_o=1 and all cmd fields held stable.
  - On cmd_wrdy_i, go to RESP. Transfer occurs on the edge where val&rdy.
- RESP:
  - res_rrdy_o=1.
  - Every res_rval_i beat is consumed.
  - If res_tid_i != TID, the beat is discarded. No master-side effect.
  - If the ID matches, the next cycle has wbm_ack_o=1 for exactly one cycle, with wbm_dat_o=res_dat_i and wbm_err_o=res_err_i. The beat counter decrements.
  - Terminal beat is one of: res_lack_i, res_err_i, or beat counter == 1. On a terminal beat: wbm_lack_o=1 with the ack, and go to DONE.
- DONE:
  - Lasts one cycle; the master deasserts stb here.
  - res_rrdy_o=0. Go to IDLE.
  - New stb is not sampled until IDLE.
- Writes:
  - Always single-beat.
  - A Wishbone write burst becomes successive CMD/RESP/DONE rounds, one per beat.
- Latency:
  - Minimum stb-to-ack is 3 cycles: IDLE→CMD, CMD accept, response registered.
  - A zero-wait response path gives ack on the cycle after the response handshake.
- Dropping stb/cyc in RESP does not abort; the remaining responses are drained without ack.
- wbm_dat_o holds its last value when no ack.
- A response arriving in IDLE, CMD or DONE is not accepted (rrdy=0).

Optional Feature:
Macro WBI_MASTER_TIMEOUT_EN.
- Enabled:
  - Counter clears on entry to RESP and on every matching beat.
  - Counts every RESP cycle without a matching beat.
  - At TO_CYC it forces wbm_ack_o=1, wbm_err_o=1, wbm_lack_o=1, wbm_dat_o=0, and goes to DONE.
  - Later stale responses with matching TID arriving in RESP of a new transaction are indistinguishable; software must reset after timeout.
- Disabled:
  - No counter logic.
  - RESP waits indefinitely.
  - TO_CYC is ignored.

Test Plan:
- Single read:
  - Stimulus: adr=0x1000_0004, bl=1, cmd_wrdy_i=1, response one cycle later with dat=0xDEAD_BEEF, lack=1, tid=TID.
  - Required: one command with bl=1; wbm_ack_o=wbm_lack_o=1 for one cycle with wbm_dat_o=0xDEAD_BEEF, 3 cycles after stb; DONE then IDLE.
- Read burst:
  - Stimulus: bl=4, responses 0x11..0x44, lack only on last.
  - Required: exactly one command; four single-cycle acks in order; lack only with 0x44.
- Backpressure:
  - Stimulus: cmd_wrdy_i low 5 cycles.
  - Required: cmd_wval_o and fields stable all 5 cycles; single accept; no duplicate command.
- TID filter:
  - Stimulus: response with tid=TID^1 then tid=TID.
  - Required: first beat consumed with no ack; ack only for second.
- Write burst of 2 beats, err on the second:
  - Required: two commands, each with we=1, bl=1; second ack has wbm_err_o=1.
- Reset in RESP (and, with WBI_MASTER_TIMEOUT_EN and TO_CYC=16, no response):
  - Reset case: outputs zero next cycle; state IDLE.
  - Timeout case: ack+err+lack exactly 16 RESP cycles after command accept.

Source files
------------

// File: rtl/wbi_master_port_if.sv
// rtl/wbi_master_port_if.sv - Wishbone master side plus command/response channel signal bundle
interface wbi_master_port_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4,
    parameter int BL = 10
);
    logic          wbm_stb_i;
    logic          wbm_cyc_i;
    logic [AW-1:0] wbm_adr_i;
    logic          wbm_we_i;
    logic [DW-1:0] wbm_dat_i;
    logic [BW-1:0] wbm_sel_i;
    logic [BL-1:0] wbm_bl_i;
    logic [DW-1:0] wbm_dat_o;
    logic          wbm_ack_o;
    logic          wbm_lack_o;
    logic          wbm_err_o;

    logic          cmd_wrdy_i;
    logic          cmd_wval_o;
    logic [AW-1:0] cmd_adr_o;
    logic          cmd_we_o;
    logic [DW-1:0] cmd_dat_o;
    logic [BW-1:0] cmd_sel_o;
    logic [3:0]    cmd_tid_o;
    logic [BL-1:0] cmd_bl_o;

    logic          res_rrdy_o;
    logic          res_rval_i;
    logic [DW-1:0] res_dat_i;
    logic          res_ack_i;
    logic          res_lack_i;
    logic          res_err_i;
    logic [3:0]    res_tid_i;

    // Bridge-side view: consumes the Wishbone request and response channel, drives commands.
    modport master (
        input  wbm_stb_i, wbm_cyc_i, wbm_adr_i, wbm_we_i, wbm_dat_i, wbm_sel_i, wbm_bl_i,
        output wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o,
        input  cmd_wrdy_i,
        output cmd_wval_o, cmd_adr_o, cmd_we_o, cmd_dat_o, cmd_sel_o, cmd_tid_o, cmd_bl_o,
        output res_rrdy_o,
        input  res_rval_i, res_dat_i, res_ack_i, res_lack_i, res_err_i, res_tid_i
    );

    modport slave (
        output wbm_stb_i, wbm_cyc_i, wbm_adr_i, wbm_we_i, wbm_dat_i, wbm_sel_i, wbm_bl_i,
        input  wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o,
        output cmd_wrdy_i,
        input  cmd_wval_o, cmd_adr_o, cmd_we_o, cmd_dat_o, cmd_sel_o, cmd_tid_o, cmd_bl_o,
        input  res_rrdy_o,
        output res_rval_i, res_dat_i, res_ack_i, res_lack_i, res_err_i, res_tid_i
    );
endinterface

// File: rtl/wbi_master_port.sv
// rtl/wbi_master_port.sv - Wishbone master to tagged command/response bridge
// Optional response timeout: define WBI_MASTER_TIMEOUT_EN.
module wbi_master_port #(
    parameter int         AW     = 32,
    parameter int         DW     = 32,
    parameter int         BW     = 4,
    parameter int         BL     = 10,
    parameter logic [3:0] TID    = 4'h0,
    parameter int         TO_CYC = 1023
) (
    input  logic              mclk,
    input  logic              reset,
    wbi_master_port_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic [BW-1:0] sel_q, sel_d;
    logic [BL-1:0] bl_q, bl_d;
    logic [BL-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdat_q, rdat_d;
    logic          ack_q, ack_d;
    logic          lack_q, lack_d;
    logic          err_q, err_d;
    logic          drain_q, drain_d;

    logic          req;
    logic          match;
    logic          terminal;
    logic          deliver;
    logic          timeout;
    logic [BL-1:0] bl_eff;

    assign req      = bus.wbm_stb_i & bus.wbm_cyc_i;
    assign match    = (state_q == S_RESP) & bus.res_rval_i & (bus.res_tid_i == TID);
    assign terminal = bus.res_lack_i | bus.res_err_i | (cnt_q == BL'(1));
    // Once the master walks away mid-burst, remaining beats are drained silently.
    assign deliver  = req & ~drain_q;
    assign bl_eff   = bus.wbm_we_i ? BL'(1) :
                      ((bus.wbm_bl_i == '0) ? BL'(1) : bus.wbm_bl_i);

`ifdef WBI_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_CMD) begin
            to_cnt_d = '0;
        end else if (state_q == S_RESP) begin
            to_cnt_d = match ? '0 : to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout = (state_q == S_RESP) & ~match & (to_cnt_q == TW'(TO_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_CMD;
            S_CMD:   if (bus.cmd_wrdy_i) state_d = S_RESP;
            S_RESP:  if ((match & terminal) | timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_wval_o = 1'b0;
        bus.res_rrdy_o = 1'b0;
        case (state_q)
            S_CMD:   bus.cmd_wval_o = 1'b1;
            S_RESP:  bus.res_rrdy_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        adr_d  = adr_q;
        we_d   = we_q;
        wdat_d = wdat_q;
        sel_d  = sel_q;
        bl_d   = bl_q;
        cnt_d  = cnt_q;
        if ((state_q == S_IDLE) && req) begin
            adr_d  = bus.wbm_adr_i;
            we_d   = bus.wbm_we_i;
            wdat_d = bus.wbm_dat_i;
            sel_d  = bus.wbm_sel_i;
            bl_d   = bl_eff;
            cnt_d  = bl_eff;
        end else if (match) begin
            cnt_d = cnt_q - BL'(1);
        end

        ack_d  = (match & deliver) | timeout;
        lack_d = (match & deliver & terminal) | timeout;
        err_d  = (match & deliver & bus.res_err_i) | timeout;
        rdat_d = rdat_q;
        if (timeout) begin
            rdat_d = '0;
        end else if (match & deliver) begin
            rdat_d = bus.res_dat_i;
        end

        drain_d = (state_q == S_RESP) & (drain_q | ~req);
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            sel_q   <= '0;
            bl_q    <= '0;
            cnt_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            lack_q  <= 1'b0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            bl_q    <= bl_d;
            cnt_q   <= cnt_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            lack_q  <= lack_d;
            err_q   <= err_d;
            drain_q <= drain_d;
        end
    end

    assign bus.cmd_adr_o  = adr_q;
    assign bus.cmd_we_o   = we_q;
    assign bus.cmd_dat_o  = wdat_q;
    assign bus.cmd_sel_o  = sel_q;
    assign bus.cmd_tid_o  = TID;
    assign bus.cmd_bl_o   = bl_q;
    assign bus.wbm_dat_o  = rdat_q;
    assign bus.wbm_ack_o  = ack_q;
    assign bus.wbm_lack_o = lack_q;
    assign bus.wbm_err_o  = err_q;
endmodule
